// File: rtl/fp_pkg.sv
// Shared float-path types: significand/product widths and multiplier FSM states.
// Used by mant_mul_iter and its step datapath.
package fp_pkg;

  localparam int MANT_W_DEF = 24;

  typedef logic [MANT_W_DEF-1:0]   mant_t;
  typedef logic [2*MANT_W_DEF-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mm_state_t;

endpackage

// File: rtl/mant_mul_iter_if.sv
// Operand/product valid-ready bundle for the iterative significand multiplier.
// master drives operands and consumes the product; slave is the multiplier.
interface mant_mul_iter_if #(
  parameter int MANT_W = 24
);

  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_W-1:0]     a;
  logic [MANT_W-1:0]     b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*MANT_W-1:0]   p;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  p
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output p
  );

endinterface

// File: rtl/mant_mul_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand,
// then advance multiplicand left and multiplier right.
module mant_mul_step #(
  parameter int MANT_W = 24
) (
  input  logic [2*MANT_W-1:0] acc_i,
  input  logic [2*MANT_W-1:0] md_i,
  input  logic [MANT_W-1:0]   mr_i,
  output logic [2*MANT_W-1:0] acc_o,
  output logic [2*MANT_W-1:0] md_o,
  output logic [MANT_W-1:0]   mr_o
);

  assign acc_o = mr_i[0] ? (acc_i + md_i) : acc_i;
  assign md_o  = md_i << 1;
  assign mr_o  = mr_i >> 1;

endmodule

// File: rtl/mant_mul_iter.sv
// Iterative 24x24 significand multiplier, one shift-add step per cycle.
// Define MANT_MUL_EARLY_EXIT_EN to finish as soon as the multiplier is exhausted.
module mant_mul_iter
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  mant_mul_iter_if.slave bus
);

  localparam int CW = $clog2(MANT_W);
  localparam logic [CW-1:0] LAST = CW'(MANT_W - 1);

  mm_state_t           state_q, state_d;
  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [2*MANT_W-1:0] md_q, md_d;
  logic [MANT_W-1:0]   mr_q, mr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [2*MANT_W-1:0] acc_nx;
  logic [2*MANT_W-1:0] md_nx;
  logic [MANT_W-1:0]   mr_nx;
  logic                last_step;

  mant_mul_step #(
    .MANT_W (MANT_W)
  ) u_step (
    .acc_i (acc_q),
    .md_i  (md_q),
    .mr_i  (mr_q),
    .acc_o (acc_nx),
    .md_o  (md_nx),
    .mr_o  (mr_nx)
  );

`ifdef MANT_MUL_EARLY_EXIT_EN
  // b==0 still takes one step, which leaves mr==0 and acc==0
  assign last_step = (cnt_q == LAST) || (mr_nx == '0);
`else
  assign last_step = (cnt_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    md_d    = md_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = '0;
          md_d    = {{MANT_W{1'b0}}, bus.a};
          mr_d    = bus.b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        md_d  = md_nx;
        mr_d  = mr_nx;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      md_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = acc_q;

endmodule
